rr_grant_arbiter: RTL and testbench
===================================

// Module: rr_grant_arbiter
// PURPOSE
//   Round-robin arbiter sharing one resource among 4 requesters; the winner index drives a
//   2-to-4 one-hot decoder (grant = 4'b0001 << grant_idx). Sits ahead of the shared datapath
//   and sequences ownership: grant held while owner requests, bounded by a hold timeout,
//   one idle gap cycle between owners. Priority rotates so no requester starves.
// PARAMETERS
//   MAX_HOLD  8  max consecutive cycles one owner keeps the grant (legal range 2..255)
//   CNT_W     8  width of hold counter; must satisfy MAX_HOLD <= 2**CNT_W-1
// PORTS
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous reset, active-high
//   req          in   4  request per requester, level; bit i = requester i
//   grant        out  4  one-hot grant, = 4'b0001 << grant_idx when grant_valid, else 4'b0000
//   grant_idx    out  2  binary index of current owner (holds last owner when !grant_valid)
//   grant_valid  out  1  resource currently owned
//   expired      out  1  1-cycle pulse: current grant revoked by hold timeout
// BEHAVIOUR
//   - All outputs registered. Reset: grant=0, grant_idx=0, grant_valid=0, expired=0,
//     hold counter=0, state=IDLE, last_owner=3 (requester 0 highest priority after reset).
//   - Priority order: last_owner+1, +2, +3, +4 (mod 4). The last owner is lowest priority.
//   - States:
//     IDLE: if |req, pick first set bit in priority order -> GRANT; grant_idx=winner,
//           grant_valid=1, hold counter=1, all visible at the next edge (latency 1 cycle
//           from req sampled to grant). If req==0, stay in IDLE.
//     GRANT: each cycle,
//           * req[grant_idx]==0 -> GAP (normal release); grant_valid=0 next cycle.
//           * else if counter==MAX_HOLD -> GAP; expired=1 for that one cycle. This is a
//             forced release.
//           * else counter++.
//           On leaving GRANT: last_owner<=grant_idx, counter<=0.
//     GAP: exactly one cycle with grant=0 (resource turnaround), then -> IDLE arbitration
//           logic applied in the same cycle. GAP->GRANT is direct if |req, so a
//           back-to-back handover costs one dead cycle.
//   - An owner holds at most MAX_HOLD cycles of grant_valid=1 per tenure.
//   - A requester whose req is held after timeout may win again only if no other
//     requester is active. In that case it rewins after the GAP cycle.
//   - req changes of non-owners during GRANT are ignored until arbitration.
//   - Simultaneous release and timeout in the same cycle: treated as a normal release,
//     expired=0.
//   - rst asserted mid-tenure: next edge forces the reset values. No expired pulse.
//     Priority returns to requester 0.
//   - Invariants: grant is one-hot or zero. grant!=0 iff grant_valid.
//     grant_idx stable while grant_valid.
// TESTING
//   1. rst 2 cycles, req=4'b0000 -> grant=0, valid=0, expired=0 throughout.
//   2. req=4'b1111 held -> owners 0,1,2,3,0 in sequence. Each owner has 8 valid cycles,
//      then expired pulses, then 1 gap cycle.
//   3. req=4'b0100 for 3 cycles then 0 -> grant=4'b0100 for 3 cycles, GAP, IDLE,
//      no expired pulse.
//   4. Owner 1 releases while req=4'b1011 -> next owner 3 (not 0), after 1 gap cycle.
//   5. Only req[2] held for 20 cycles -> grant 8 cycles, expired, gap, regrant 2.
//      Repeats, never starves.
//   6. rst pulsed at the 4th cycle of owner 2's tenure -> all outputs 0 next edge.
//      With req=4'b1111, the winner is 0.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Round-robin arbiter sharing one resource among four requesters. The winner
//   holds the grant while it keeps requesting, for at most MAX_HOLD cycles per
//   tenure. Every release, normal or forced, is followed by exactly one gap cycle
//   with no grant so the shared datapath can turn around. Priority rotates from
//   the last owner, so an active requester cannot be starved.
//
// Parameters
//   MAX_HOLD     maximum consecutive grant cycles per tenure (2..255)
//   CNT_W        hold counter width; MAX_HOLD must fit in CNT_W bits
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   req[3:0]     level request per requester
//   grant[3:0]   one-hot grant (4'b0001 << grant_idx) while grant_valid, else 0
//   grant_idx    index of the current owner; holds the last owner when idle
//   grant_valid  resource currently owned
//   expired      one-cycle pulse when a grant is revoked by the hold timeout
module rr_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       expired
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [1:0]       last_owner_q;

    logic [1:0]       win_idx;
    logic [1:0]       cand;

    // Search last_owner+1 .. last_owner+4; scanning from the far end down means
    // the nearest requester in priority order is the last one written.
    always_comb begin
        win_idx = last_owner_q + 2'd1;
        cand    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = last_owner_q + 2'd1 + 2'(k);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            last_owner_q <= 2'd3;
            grant        <= 4'b0000;
            grant_idx    <= 2'd0;
            grant_valid  <= 1'b0;
            expired      <= 1'b0;
        end else begin
            expired <= 1'b0;
            unique case (state_q)
                // The gap cycle arbitrates exactly like idle, so a waiting
                // requester is granted right after the single dead cycle.
                StIdle, StGap: begin
                    if (|req) begin
                        state_q     <= StGrant;
                        grant_idx   <= win_idx;
                        grant       <= 4'b0001 << win_idx;
                        grant_valid <= 1'b1;
                        hold_cnt_q  <= CntOne;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    // A normal release takes precedence over a coincident timeout.
                    if (!req[grant_idx] || hold_cnt_q == HoldMax) begin
                        state_q      <= StGap;
                        grant        <= 4'b0000;
                        grant_valid  <= 1'b0;
                        last_owner_q <= grant_idx;
                        hold_cnt_q   <= '0;
                        expired      <= req[grant_idx];
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       expired;

    int tests;
    int fails;

    // {grant, grant_idx, grant_valid, expired}
    logic [7:0] observed;
    logic [7:0] exp_v;

    assign observed = {grant, grant_idx, grant_valid, expired};

    rr_grant_arbiter #(
        .MAX_HOLD(8),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            exp_v = 8'b0000_00_0_0;
            tests++;
            if (observed !== exp_v) begin
                fails++;
                $display("FAIL reset cycle %0d: got %b want %b", c, observed, exp_v);
            end
        end
        rst = 1'b0;
        tick();
        exp_v = 8'b0000_00_0_0;
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL reset_idle: got %b want %b", observed, exp_v);
        end
    endtask

    task automatic test_rotation();
        int owners [5];
        owners = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                exp_v = {4'b0001 << owners[t], 2'(owners[t]), 1'b1, 1'b0};
                tests++;
                if (observed !== exp_v) begin
                    fails++;
                    $display("FAIL rotation tenure %0d cycle %0d: got %b want %b",
                             t, c, observed, exp_v);
                end
            end
            tick();
            exp_v = {4'b0000, 2'(owners[t]), 1'b0, 1'b1};
            tests++;
            if (observed !== exp_v) begin
                fails++;
                $display("FAIL rotation gap %0d: got %b want %b", t, observed, exp_v);
            end
        end
        req = 4'b0000;
        tick();
        exp_v = {4'b0000, 2'd0, 1'b0, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL rotation idle: got %b want %b", observed, exp_v);
        end
    endtask

    task automatic test_release();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
            tests++;
            if (observed !== exp_v) begin
                fails++;
                $display("FAIL release grant cycle %0d: got %b want %b", c, observed, exp_v);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            exp_v = {4'b0000, 2'd2, 1'b0, 1'b0};
            tests++;
            if (observed !== exp_v) begin
                fails++;
                $display("FAIL release gap/idle %0d: got %b want %b", c, observed, exp_v);
            end
        end
    endtask

    task automatic test_skip();
        // last owner is 2 here, so a lone req[1] wins
        req = 4'b0010;
        tick();
        exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL skip owner1: got %b want %b", observed, exp_v);
        end
        // Non-owner requests appear; owner 1 keeps the grant
        req = 4'b1011;
        tick();
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL skip hold: got %b want %b", observed, exp_v);
        end
        // Owner 1 drops; 0 and 3 wait, 3 comes first after 1
        req = 4'b1001;
        tick();
        exp_v = {4'b0000, 2'd1, 1'b0, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL skip gap: got %b want %b", observed, exp_v);
        end
        tick();
        exp_v = {4'b1000, 2'd3, 1'b1, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL skip next owner: got %b want %b", observed, exp_v);
        end
        req = 4'b0000;
        tick();
        tick();
        exp_v = {4'b0000, 2'd3, 1'b0, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL skip idle: got %b want %b", observed, exp_v);
        end
    endtask

    task automatic test_single_timeout();
        req = 4'b0100;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
                tests++;
                if (observed !== exp_v) begin
                    fails++;
                    $display("FAIL single tenure %0d cycle %0d: got %b want %b",
                             t, c, observed, exp_v);
                end
            end
            tick();
            exp_v = {4'b0000, 2'd2, 1'b0, 1'b1};
            tests++;
            if (observed !== exp_v) begin
                fails++;
                $display("FAIL single expired %0d: got %b want %b", t, observed, exp_v);
            end
        end
        req = 4'b0000;
        tick();
        exp_v = {4'b0000, 2'd2, 1'b0, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL single idle: got %b want %b", observed, exp_v);
        end
    endtask

    task automatic test_release_at_limit();
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            tick();
        end
        exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL limit last cycle: got %b want %b", observed, exp_v);
        end
        // Drop req in the cycle the counter hits the limit: normal release
        req = 4'b0000;
        tick();
        exp_v = {4'b0000, 2'd0, 1'b0, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL limit release: got %b want %b", observed, exp_v);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        // last owner is 0, so a lone req[2] wins
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL midrst owner2: got %b want %b", observed, exp_v);
        end
        rst = 1'b1;
        req = 4'b1111;
        tick();
        exp_v = 8'b0000_00_0_0;
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL midrst cleared: got %b want %b", observed, exp_v);
        end
        rst = 1'b0;
        tick();
        exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
        tests++;
        if (observed !== exp_v) begin
            fails++;
            $display("FAIL midrst winner0: got %b want %b", observed, exp_v);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        test_reset();
        test_rotation();
        test_release();
        test_skip();
        test_single_timeout();
        test_release_at_limit();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
